// File: rtl/edge_detect.sv
// edge_detect: synchronizes a 1-bit level input and turns it into registered
// one-cycle pulses for rising edges, falling edges and a selectable edge type.
// It also keeps a wrapping count of selected-edge pulses.
// Optional glitch filter: define EDGE_DETECT_GLITCH_FILTER_EN to enable it.
// When enabled, the filtered level changes only after the synchronized input
// has held its new value for FILTER_LEN consecutive clocks.
module edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 2,
  parameter int CNT_W       = 8,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             din,
  output logic             flag,
  output logic             rise,
  output logic             fall,
  output logic             level,
  output logic [CNT_W-1:0] edge_cnt
);

  // Elaboration-time range checks on the parameters
  if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("edge_detect: SYNC_STAGES must be 0..4");
  end
  if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
    $error("edge_detect: EDGE_TYPE must be 0..2");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
    $error("edge_detect: CNT_W must be 1..32");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filt
    $error("edge_detect: FILTER_LEN must be 1..15");
  end

  logic             w_s;
  logic             w_lvl;
  logic             w_re;
  logic             w_fe;
  logic             w_flag_nxt;
  logic             r_prev;
  logic             r_rise;
  logic             r_fall;
  logic             r_flag;
  logic [CNT_W-1:0] r_cnt;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_s = din;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;

    // Metastability chain: din enters at bit 0, the synchronized level leaves from the top bit
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          r_sync[i] <= r_sync[i-1];
        end
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];
  end

`ifdef EDGE_DETECT_GLITCH_FILTER_EN
  localparam logic [3:0] LP_FRELOAD = 4'(FILTER_LEN - 1);

  logic       r_filt;
  logic [3:0] r_fcnt;

  // Down-counter reloads while the input agrees with the filtered level.
  // The level flips when the counter reaches terminal count with the input still differing.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_fcnt <= LP_FRELOAD;
    end else if (w_s == r_filt) begin
      r_fcnt <= LP_FRELOAD;
    end else if (r_fcnt == 4'd0) begin
      r_filt <= w_s;
      r_fcnt <= LP_FRELOAD;
    end else begin
      r_fcnt <= r_fcnt - 4'd1;
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = w_s;
`endif

  assign w_re = w_lvl & ~r_prev;
  assign w_fe = ~w_lvl & r_prev;

  // Pick the edge type that drives flag and edge_cnt
  always_comb begin
    w_flag_nxt = w_re | w_fe;
    case (EDGE_TYPE)
      0:       w_flag_nxt = w_re;
      1:       w_flag_nxt = w_fe;
      default: w_flag_nxt = w_re | w_fe;
    endcase
  end

  // Previous level, registered pulses and the wrapping edge counter
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_flag <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_lvl;
      r_rise <= w_re;
      r_fall <= w_fe;
      r_flag <= w_flag_nxt;
      if (w_flag_nxt) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign flag     = r_flag;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign level    = r_prev;
  assign edge_cnt = r_cnt;

endmodule

// File: tb/tb_edge_detect.sv
// tb_edge_detect: directed tests for edge_detect across several parameter sets.
module tb_edge_detect;

  logic clock;
  logic rst_n;
  logic din_a;
  logic din_f;
  logic din_w;
  logic din_g;

  logic       def_flag, def_rise, def_fall, def_level;
  logic [7:0] def_cnt;
  logic       e0_flag, e0_rise, e0_fall, e0_level;
  logic [7:0] e0_cnt;
  logic       e1_flag, e1_rise, e1_fall, e1_level;
  logic [7:0] e1_cnt;
  logic       f_flag, f_rise, f_fall, f_level;
  logic [7:0] f_cnt;
  logic       w_flag, w_rise, w_fall, w_level;
  logic [1:0] w_cnt;
  logic       g_flag, g_rise, g_fall, g_level;
  logic [7:0] g_cnt;

  int n_checks;
  int n_fail;

  edge_detect u_def (
    .clock(clock), .rst_n(rst_n), .din(din_a), .flag(def_flag), .rise(def_rise),
    .fall(def_fall), .level(def_level), .edge_cnt(def_cnt)
  );

  edge_detect #(.EDGE_TYPE(0)) u_e0 (
    .clock(clock), .rst_n(rst_n), .din(din_a), .flag(e0_flag), .rise(e0_rise),
    .fall(e0_fall), .level(e0_level), .edge_cnt(e0_cnt)
  );

  edge_detect #(.EDGE_TYPE(1)) u_e1 (
    .clock(clock), .rst_n(rst_n), .din(din_a), .flag(e1_flag), .rise(e1_rise),
    .fall(e1_fall), .level(e1_level), .edge_cnt(e1_cnt)
  );

  edge_detect #(.SYNC_STAGES(0)) u_fast (
    .clock(clock), .rst_n(rst_n), .din(din_f), .flag(f_flag), .rise(f_rise),
    .fall(f_fall), .level(f_level), .edge_cnt(f_cnt)
  );

  edge_detect #(.SYNC_STAGES(0), .EDGE_TYPE(0), .CNT_W(2)) u_wrap (
    .clock(clock), .rst_n(rst_n), .din(din_w), .flag(w_flag), .rise(w_rise),
    .fall(w_fall), .level(w_level), .edge_cnt(w_cnt)
  );

  edge_detect #(.FILTER_LEN(3)) u_filt (
    .clock(clock), .rst_n(rst_n), .din(din_g), .flag(g_flag), .rise(g_rise),
    .fall(g_fall), .level(g_level), .edge_cnt(g_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp4;
    rst_n = 1'b0;
    din_a = 1'b1;
    din_f = 1'b0;
    din_w = 1'b0;
    din_g = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({def_flag, def_rise, def_fall, def_level} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000", {def_flag, def_rise, def_fall, def_level});
    end
    n_checks++;
    if (def_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", def_cnt);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp4 = {(i == 3), (i == 3), 1'b0, (i >= 3)};
      n_checks++;
      if ({def_flag, def_rise, def_fall, def_level} !== exp4) begin
        n_fail++;
        $display("FAIL release_pipeline tick %0d: got flag/rise/fall/level %b want %b", i,
                 {def_flag, def_rise, def_fall, def_level}, exp4);
      end
    end
    n_checks++;
    if (def_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL release_cnt: got %0d want 1", def_cnt);
    end
    n_checks++;
    if ({e0_cnt, e1_cnt} !== {8'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL release_cnt_e0_e1: got %0d/%0d want 1/0", e0_cnt, e1_cnt);
    end
  endtask

  task automatic test_both_edges();
    logic [3:0] exp4;
    logic [1:0] exp_f01;
    din_a = 1'b0;
    repeat (5) tick();
    do_reset();
    din_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) din_a = 1'b0;
      exp4 = {(i == 3) || (i == 5), (i == 3), (i == 5), (i == 3) || (i == 4)};
      n_checks++;
      if ({def_flag, def_rise, def_fall, def_level} !== exp4) begin
        n_fail++;
        $display("FAIL both_edges tick %0d: got flag/rise/fall/level %b want %b", i,
                 {def_flag, def_rise, def_fall, def_level}, exp4);
      end
      exp_f01 = {(i == 3), (i == 5)};
      n_checks++;
      if ({e0_flag, e1_flag} !== exp_f01) begin
        n_fail++;
        $display("FAIL edge_type_flags tick %0d: got e0/e1 %b want %b", i, {e0_flag, e1_flag}, exp_f01);
      end
      n_checks++;
      if ({e0_rise, e0_fall, e1_rise, e1_fall} !== {(i == 3), (i == 5), (i == 3), (i == 5)}) begin
        n_fail++;
        $display("FAIL edge_type_rise_fall tick %0d: got %b", i, {e0_rise, e0_fall, e1_rise, e1_fall});
      end
    end
    n_checks++;
    if ({def_cnt, e0_cnt, e1_cnt} !== {8'd2, 8'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL both_edges_cnt: got %0d/%0d/%0d want 2/1/1", def_cnt, e0_cnt, e1_cnt);
    end
  endtask

  task automatic test_fast_toggle();
    for (int i = 1; i <= 8; i++) begin
      din_f = ~din_f;
      tick();
      n_checks++;
      if ({f_flag, f_cnt} !== {1'b1, 8'(i)}) begin
        n_fail++;
        $display("FAIL fast_toggle tick %0d: got flag %b cnt %0d want 1 %0d", i, f_flag, f_cnt, i);
      end
      n_checks++;
      if ((f_rise & f_fall) !== 1'b0) begin
        n_fail++;
        $display("FAIL rise_fall_exclusive tick %0d: got rise %b fall %b want not both", i, f_rise, f_fall);
      end
    end
    tick();
    n_checks++;
    if ({f_flag, f_cnt} !== {1'b0, 8'd8}) begin
      n_fail++;
      $display("FAIL fast_toggle_end: got flag %b cnt %0d want 0 8", f_flag, f_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      din_w = 1'b1;
      tick();
      n_checks++;
      if ({w_flag, w_cnt} !== {1'b1, exp_seq[i]}) begin
        n_fail++;
        $display("FAIL wrap event %0d: got flag %b cnt %0d want 1 %0d", i, w_flag, w_cnt, exp_seq[i]);
      end
      din_w = 1'b0;
      tick();
    end
  endtask

  task automatic test_async_reset();
    din_a = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({def_flag, def_cnt} !== {1'b1, 8'd3}) begin
      n_fail++;
      $display("FAIL async_pre: got flag %b cnt %0d want 1 3", def_flag, def_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({def_flag, def_rise, def_level, def_cnt} !== {3'b000, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset_now: got flag %b rise %b level %b cnt %0d want 0 0 0 0",
               def_flag, def_rise, def_level, def_cnt);
    end
    tick();
    din_a = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({def_flag, def_rise, def_fall, def_cnt} !== {3'b000, 8'd0}) begin
        n_fail++;
        $display("FAIL async_after tick %0d: got flag %b rise %b fall %b cnt %0d want 0 0 0 0",
                 i, def_flag, def_rise, def_fall, def_cnt);
      end
    end
  endtask

  task automatic test_glitch();
    int lat;
`ifdef EDGE_DETECT_GLITCH_FILTER_EN
    lat = 6;
    din_g = 1'b1;
    tick();
    tick();
    din_g = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_checks++;
      if ({g_flag, g_rise, g_fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL glitch_suppressed tick %0d: got flag/rise/fall %b want 000", i, {g_flag, g_rise, g_fall});
      end
    end
`else
    lat = 3;
`endif
    din_g = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (g_flag !== (i == lat)) begin
        n_fail++;
        $display("FAIL long_pulse tick %0d: got flag %b want %b", i, g_flag, (i == lat));
      end
    end
    n_checks++;
    if (g_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL long_pulse_cnt: got %0d want 1", g_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_both_edges();
    test_fast_toggle();
    test_wrap();
    test_async_reset();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_detect.md
Name: edge_detect

Overview:
- Single-clock input edge detector.
- Optionally synchronizes an asynchronous 1-bit input, then detects rising and/or falling transitions.
- Emits a registered one-cycle pulse per detected edge and keeps a running edge count.
- Used in front of control logic that needs pulse-per-event from level signals such as buttons, strobes and handshake lines.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on din (legal 0..4; 0 = din already synchronous, no synchronizer).
- EDGE_TYPE, 2, edge selection for flag: 0 = rising only, 1 = falling only, 2 = both.
- CNT_W, 8, width of edge_cnt (legal 1..32).
- FILTER_LEN, 3, stable-sample count for the optional glitch filter (legal 1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  level input, may be asynchronous to clock.
- flag  out  1  one-cycle pulse for each edge of the type selected by EDGE_TYPE.
- rise  out  1  one-cycle pulse on every rising edge, independent of EDGE_TYPE.
- fall  out  1  one-cycle pulse on every falling edge, independent of EDGE_TYPE.
- level  out  1  current synchronized (and filtered) level of din.
- edge_cnt  out  CNT_W  count of flag pulses since reset.

Interface decision:
- One clock; reset is asynchronous and active-low (clock port "clock", reset port "rst_n").

Behaviour:
- Reset (rst_n = 0, asserted asynchronously, takes effect immediately):
  - All synchronizer flops, the previous-level register, level, flag, rise and fall go to 0.
  - edge_cnt goes to 0.
  - Release is synchronous in effect: the first sampling occurs on the first clock rising edge with rst_n = 1.
- Synchronizer:
  - s is din delayed through SYNC_STAGES flops.
  - When SYNC_STAGES = 0, s = din combinationally.
- Previous level:
  - p <= s every clock.
  - level = p.
- Edge terms:
  - re = s & ~p; fe = ~s & p.
  - rise <= re; fall <= fe.
  - flag <= re when EDGE_TYPE = 0, fe when EDGE_TYPE = 1, (re | fe) when EDGE_TYPE = 2.
  - All three outputs are registered.
- Latency, measured from the first clock edge that samples the new din value:
  - The flag pulse appears after that edge and lasts exactly one clock period.
  - Total latency = SYNC_STAGES + 1 clocks from din change to flag high.
- Because the reset level is 0, din held high through reset release produces one rise (and one flag if EDGE_TYPE != 1) after the pipeline fills.
- A din pulse shorter than one clock period may be missed. This is not an error; no detection is guaranteed.
- din toggling every clock with SYNC_STAGES >= 0 produces a flag on every clock. Back-to-back pulses are legal.
- rise and fall are never high in the same cycle.
- edge_cnt:
  - Increments by 1 in the same cycle flag is registered high.
  - Wraps from all ones to 0; no saturation.
- Reset mid-operation:
  - Outputs clear immediately, in-flight edges are discarded, and the count restarts at 0.
- Parameter out of legal range: compile-time error via generate-time check.

Optional Feature:
- Macro: EDGE_DETECT_GLITCH_FILTER_EN.
- Defined:
  - A filter sits between s and the edge logic.
  - The filtered level changes only after s holds its new value for FILTER_LEN consecutive clocks.
  - The filter uses a counter that reloads whenever s equals the current filtered level.
  - The filtered level replaces s in the re/fe terms and in p.
  - Latency grows by FILTER_LEN clocks.
  - Pulses on s shorter than FILTER_LEN clocks produce no rise, fall or flag.
  - The filter state resets to 0.
- Undefined: no filter logic; behaviour exactly as above.

Test Plan:
- Reset/pipeline: rst_n low with din = 1, release, hold din = 1 (defaults) -> all outputs 0 during reset; single rise/flag pulse 3 clocks after release; edge_cnt = 1.
- Both edges (EDGE_TYPE = 2): din 0->1, hold 2 clocks, 1->0, hold 2 clocks -> flag pulses twice, each 1 cycle wide, 3 clocks after each change; rise then fall; edge_cnt = 2.
- EDGE_TYPE = 0 and 1, same stimulus -> flag only on rise (resp. fall); rise/fall outputs unchanged; edge_cnt = 1.
- Fast toggle (SYNC_STAGES = 0): din toggles every clock for 8 clocks -> flag high 8 consecutive cycles; edge_cnt = 8.
- Wrap with CNT_W = 2: 5 flag events -> edge_cnt sequence 1, 2, 3, 0, 1.
- Async reset mid-pulse: assert rst_n between clock edges while flag = 1 -> flag and edge_cnt drop to 0 immediately; with EDGE_DETECT_GLITCH_FILTER_EN and FILTER_LEN = 3, a 2-clock din pulse -> no flag.
